// File: rtl/bf16_pkg.sv
// Shared types and constants for the bf16 adder operand front-end.
// Decoded-operand layout, exponent offsets and the idle operand value.
package bf16_pkg;

    localparam int         GUARD_BITS  = 6;
    localparam int         MANT_W      = GUARD_BITS + 16;
    localparam int         EXP_OFFSET  = 127;
    localparam logic [7:0] EXP_SPECIAL = 8'hFF;

    typedef struct packed {
        logic [MANT_W-1:0] mant;
        logic [31:0]       exp;
        logic              s;
        logic              exc;
        logic              err;
    } op_t;

    localparam op_t OP_IDLE = '{
        mant: '0,
        exp:  32'(EXP_OFFSET),
        s:    1'b0,
        exc:  1'b0,
        err:  1'b0
    };

    // Infinity is a special exponent with a zero fraction.
    function automatic logic is_inf(input op_t op);
        return op.exc && !op.err;
    endfunction

endpackage

// File: rtl/bf16_unpack_op.sv
// Combinational decoder for one bf16 operand into the adder-core field format.
// Subnormals flush to zero; inf/NaN raise exc, NaN also raises err.
module bf16_unpack_op
    import bf16_pkg::*;
(
    input  logic [15:0] x,
    output op_t         op
);

    logic [7:0] e;
    logic [6:0] m;

    assign e = x[14:7];
    assign m = x[6:0];

    always_comb begin
        // NOTE: every field gets a default before the branches so no path leaves op unassigned (no latch).
        op   = OP_IDLE;
        op.s = x[15];
        if (e == EXP_SPECIAL) begin
            op.exp = 32'(EXP_SPECIAL) + 32'(EXP_OFFSET);
            op.exc = 1'b1;
            op.err = (m != '0);
        end else if (e != '0) begin
            op.mant = MANT_W'({1'b1, m, 7'b0});
            op.exp  = 32'(e) + 32'(EXP_OFFSET);
        end
    end

endmodule

// File: rtl/bf16_add_unpack.sv
// bf16 adder operand front-end: 2-entry pair FIFO, operand decode/issue registers
// and a LAT-deep valid delay line marking when the adder result belongs to an issue.
module bf16_add_unpack
    import bf16_pkg::*;
#(
    parameter int G   = 6,
    parameter int LAT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   a_i,
    input  logic [15:0]   b_i,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          issue_en,
    output logic [G+15:0] in1,
    output logic [G+15:0] in2,
    output logic [31:0]   exp_1,
    output logic [31:0]   exp_2,
    output logic          s_in1,
    output logic          s_in2,
    output logic          exc_flag_1,
    output logic          exc_flag_2,
    output logic          err_code_1,
    output logic          err_code_2,
    output logic          op_valid,
    output logic          res_valid,
    output logic [1:0]    occupancy
);

    logic [31:0]    mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           push;
    logic           pop;
    logic [31:0]    head;
    op_t            dec_a;
    op_t            dec_b;
    op_t            fix_a;
    op_t            fix_b;
    logic           inf_minus_inf;
    op_t            op_a_q;
    op_t            op_b_q;
    logic [LAT-1:0] valid_pipe;

    assign in_ready = reset && (occupancy != 2'd2);
    assign push     = in_valid && in_ready;
    assign pop      = issue_en && (occupancy != 2'd0);

    // NOTE: pair storage carries no reset; occupancy and pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {a_i, b_i};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    bf16_unpack_op u_dec_a (.x(head[31:16]), .op(dec_a));
    bf16_unpack_op u_dec_b (.x(head[15:0]),  .op(dec_b));

    // inf - inf has no defined value, so both lanes flag a NaN result.
    assign inf_minus_inf = is_inf(dec_a) && is_inf(dec_b) && (dec_a.s != dec_b.s);

    always_comb begin
        fix_a     = dec_a;
        fix_b     = dec_b;
        fix_a.err = dec_a.err || inf_minus_inf;
        fix_b.err = dec_b.err || inf_minus_inf;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_a_q   <= OP_IDLE;
            op_b_q   <= OP_IDLE;
            op_valid <= 1'b0;
        end else if (pop) begin
            op_a_q   <= fix_a;
            op_b_q   <= fix_b;
            op_valid <= 1'b1;
        end else begin
            op_a_q   <= OP_IDLE;
            op_b_q   <= OP_IDLE;
            op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_pipe <= '0;
        end else begin
            valid_pipe <= (valid_pipe << 1) | LAT'(op_valid);
        end
    end

    assign res_valid  = valid_pipe[LAT-1];

    assign in1        = (G+16)'(op_a_q.mant);
    assign in2        = (G+16)'(op_b_q.mant);
    assign exp_1      = op_a_q.exp;
    assign exp_2      = op_b_q.exp;
    assign s_in1      = op_a_q.s;
    assign s_in2      = op_b_q.s;
    assign exc_flag_1 = op_a_q.exc;
    assign exc_flag_2 = op_b_q.exc;
    assign err_code_1 = op_a_q.err;
    assign err_code_2 = op_b_q.err;

endmodule

// File: tb/tb_bf16_add_unpack.sv
// Self-checking bench for bf16_add_unpack: decode vector table, hand-written
// handshake/reset sequences and random traffic against a queue-based reference model.
module tb_bf16_add_unpack;

    localparam int G   = 6;
    localparam int LAT = 4;
    localparam int MW  = G + 16;

    typedef struct packed {
        logic [MW-1:0] mant;
        logic [31:0]   exp;
        logic          s;
        logic          exc;
        logic          err;
    } dec_t;

    typedef struct {
        logic [15:0]   a;
        logic [15:0]   b;
        logic [MW-1:0] m1;
        logic [MW-1:0] m2;
        logic [31:0]   e1;
        logic [31:0]   e2;
        logic [5:0]    flags;   // {s1, s2, exc1, exc2, err1, err2}
    } vec_t;

    localparam dec_t IDLE = '{mant: '0, exp: 32'd127, s: 1'b0, exc: 1'b0, err: 1'b0};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   a_i = '0;
    logic [15:0]   b_i = '0;
    logic          in_valid = 1'b0;
    logic          issue_en = 1'b0;
    logic          in_ready;
    logic [MW-1:0] in1, in2;
    logic [31:0]   exp_1, exp_2;
    logic          s_in1, s_in2, exc_flag_1, exc_flag_2, err_code_1, err_code_2;
    logic          op_valid, res_valid;
    logic [1:0]    occupancy;

    always #5 clk = ~clk;

    bf16_add_unpack #(.G(G), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .a_i(a_i), .b_i(b_i),
        .in_valid(in_valid), .in_ready(in_ready), .issue_en(issue_en),
        .in1(in1), .in2(in2), .exp_1(exp_1), .exp_2(exp_2),
        .s_in1(s_in1), .s_in2(s_in2),
        .exc_flag_1(exc_flag_1), .exc_flag_2(exc_flag_2),
        .err_code_1(err_code_1), .err_code_2(err_code_2),
        .op_valid(op_valid), .res_valid(res_valid), .occupancy(occupancy)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic dec_t dec1(input logic [15:0] x);
        dec_t d;
        int   e, m;
        e      = int'(x[14:7]);
        m      = int'(x[6:0]);
        d.s    = x[15];
        d.mant = '0;
        d.exp  = 32'd127;
        d.exc  = 1'b0;
        d.err  = 1'b0;
        if (e == 255) begin
            d.exp = 32'(127 + 255);
            d.exc = 1'b1;
            d.err = (m != 0);
        end else if (e != 0) begin
            d.mant = MW'(16384 + m * 128);
            d.exp  = 32'(e + 127);
        end
        return d;
    endfunction

    function automatic void dec_pair(input logic [15:0] a, input logic [15:0] b,
                                     output dec_t da, output dec_t db);
        da = dec1(a);
        db = dec1(b);
        if (a[14:0] == 15'h7F80 && b[14:0] == 15'h7F80 && a[15] != b[15]) begin
            da.err = 1'b1;
            db.err = 1'b1;
        end
    endfunction

    function automatic logic [113:0] pack_model(input dec_t x, input dec_t y);
        return {x.mant, y.mant, x.exp, y.exp, x.s, y.s, x.exc, y.exc, x.err, y.err};
    endfunction

    logic [31:0] mq[$];
    logic        hist[$];
    logic [31:0] m_pair;
    dec_t        m_a = IDLE, m_b = IDLE;
    logic        m_ov = 1'b0;
    logic        m_rv = 1'b0;
    bit          m_acc;

    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            hist.delete();
            for (int i = 0; i < LAT; i++) hist.push_back(1'b0);
            m_a  = IDLE;
            m_b  = IDLE;
            m_ov = 1'b0;
            m_rv = 1'b0;
        end else begin
            m_acc = in_valid && (mq.size() != 2);
            hist.push_front(m_ov);
            void'(hist.pop_back());
            m_rv = hist[LAT-1];
            if (issue_en && mq.size() > 0) begin
                m_pair = mq.pop_front();
                dec_pair(m_pair[31:16], m_pair[15:0], m_a, m_b);
                m_ov = 1'b1;
            end else begin
                m_a  = IDLE;
                m_b  = IDLE;
                m_ov = 1'b0;
            end
            if (m_acc) mq.push_back({a_i, b_i});
        end
    end

    // ---------------- per-cycle monitor ----------------
    bit mon_en = 0;
    int cyc = 0;
    int n_res = 0;
    int dut_acc = 0;
    int first_res = -1;
    int last_res = -1;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            check("in_ready", 128'(in_ready), 128'(reset && (mq.size() != 2)));
            check("occupancy", 128'(occupancy), 128'(mq.size()));
            check("op_valid", 128'(op_valid), 128'(m_ov));
            check("res_valid", 128'(res_valid), 128'(m_rv));
            check("operands",
                  128'({in1, in2, exp_1, exp_2, s_in1, s_in2, exc_flag_1, exc_flag_2,
                        err_code_1, err_code_2}),
                  128'(pack_model(m_a, m_b)));
            if (res_valid === 1'b1) begin
                n_res++;
                if (first_res < 0) first_res = cyc;
                last_res = cyc;
            end
            if (in_valid && in_ready === 1'b1) dut_acc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [15:0] rnd_normal();
        logic [7:0] e;
        e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 7'($urandom)};
    endfunction

    function automatic logic [15:0] rnd_any();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'h00;
            1:       e = 8'hFF;
            default: e = 8'($urandom);
        endcase
        return {1'($urandom), e, ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom)};
    endfunction

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        issue_en = 1'b0;
        step();
        reset = 1'b1;
    endtask

    vec_t vt[8];
    dec_t xa, xb;
    int   base_res, base_acc;

    initial begin
        vt[0] = '{16'h3F80, 16'h3F80, 22'h004000, 22'h004000, 32'd254, 32'd254, 6'b000000};
        vt[1] = '{16'h7F80, 16'hFF80, 22'h000000, 22'h000000, 32'd382, 32'd382, 6'b011111};
        vt[2] = '{16'h0001, 16'h8000, 22'h000000, 22'h000000, 32'd127, 32'd127, 6'b010000};
        vt[3] = '{16'h7FC1, 16'h4049, 22'h000000, 22'h006480, 32'd382, 32'd255, 6'b001010};
        vt[4] = '{16'h7F80, 16'h7F80, 22'h000000, 22'h000000, 32'd382, 32'd382, 6'b001100};
        vt[5] = '{16'hC2F7, 16'h0080, 22'h007B80, 22'h004000, 32'd260, 32'd128, 6'b100000};
        vt[6] = '{16'hFF80, 16'h7F80, 22'h000000, 22'h000000, 32'd382, 32'd382, 6'b101111};
        vt[7] = '{16'h7F7F, 16'hFFFF, 22'h007F80, 22'h000000, 32'd381, 32'd382, 6'b010101};

        // Reset state
        reset = 1'b0;
        step();
        step();
        mon_en = 1;
        check("rst_occupancy", 128'(occupancy), 128'd0);
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_op_valid", 128'(op_valid), 128'd0);
        check("rst_res_valid", 128'(res_valid), 128'd0);
        check("rst_exp_1", 128'(exp_1), 128'd127);
        reset = 1'b1;
        step();
        check("rst_release_ready", 128'(in_ready), 128'd1);

        // Decode table with exact issue and result latency
        foreach (vt[i]) begin
            a_i      = vt[i].a;
            b_i      = vt[i].b;
            in_valid = 1'b1;
            issue_en = 1'b1;
            step();                          // accept edge N
            in_valid = 1'b0;
            check("vec_not_yet_issued", 128'(op_valid), 128'd0);
            step();                          // edge N+1
            check($sformatf("vec%0d_op_valid", i), 128'(op_valid), 128'd1);
            check($sformatf("vec%0d_fields", i),
                  128'({in1, in2, exp_1, exp_2, s_in1, s_in2, exc_flag_1, exc_flag_2,
                        err_code_1, err_code_2}),
                  128'({vt[i].m1, vt[i].m2, vt[i].e1, vt[i].e2, vt[i].flags}));
            repeat (LAT - 1) step();
            check($sformatf("vec%0d_res_early", i), 128'(res_valid), 128'd0);
            step();                          // edge N+1+LAT
            check($sformatf("vec%0d_res_valid", i), 128'(res_valid), 128'd1);
        end
        step();

        // Backpressure: three pairs offered with issue disabled
        issue_en = 1'b0;
        in_valid = 1'b1;
        a_i = 16'h3F80; b_i = 16'h4000;
        step();
        a_i = 16'hC2F7; b_i = 16'h0080;
        step();
        a_i = 16'h7F80; b_i = 16'hFF80;
        step();
        check("bp_occupancy_full", 128'(occupancy), 128'd2);
        check("bp_in_ready_low", 128'(in_ready), 128'd0);
        step();
        check("bp_still_full", 128'(occupancy), 128'd2);
        issue_en = 1'b1;
        step();
        dec_pair(16'h3F80, 16'h4000, xa, xb);
        check("bp_issue0", 128'({in1, in2, exp_1, exp_2}), 128'({xa.mant, xb.mant, xa.exp, xb.exp}));
        check("bp_no_passthrough", 128'(occupancy), 128'd1);
        step();
        in_valid = 1'b0;
        dec_pair(16'hC2F7, 16'h0080, xa, xb);
        check("bp_issue1", 128'({in1, in2, exp_1, exp_2}), 128'({xa.mant, xb.mant, xa.exp, xb.exp}));
        step();
        dec_pair(16'h7F80, 16'hFF80, xa, xb);
        check("bp_issue2", 128'({in1, in2, err_code_1, err_code_2}), 128'({xa.mant, xb.mant, 2'b11}));
        check("bp_drained", 128'(occupancy), 128'd0);
        repeat (LAT + 1) step();

        // Reset mid-stream with a full FIFO and a busy delay line
        issue_en = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < LAT + 3; i++) begin
            a_i = rnd_normal();
            b_i = rnd_normal();
            step();
        end
        issue_en = 1'b0;
        a_i = rnd_normal();
        step();
        check("mid_occupancy_full", 128'(occupancy), 128'd2);
        check("mid_res_busy", 128'(res_valid), 128'd1);
        reset = 1'b0;
        step();
        check("mid_rst_occupancy", 128'(occupancy), 128'd0);
        check("mid_rst_op_valid", 128'(op_valid), 128'd0);
        check("mid_rst_res_valid", 128'(res_valid), 128'd0);
        check("mid_rst_idle", 128'({in1, in2, exp_1, exp_2, s_in1, s_in2}),
              128'({22'd0, 22'd0, 32'd127, 32'd127, 2'b00}));
        reset    = 1'b1;
        in_valid = 1'b0;
        step();
        repeat (2) step();

        // Continuous random normal stream, issue always enabled
        base_res  = n_res;
        base_acc  = dut_acc;
        first_res = -1;
        issue_en  = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 200; i++) begin
            a_i = rnd_normal();
            b_i = rnd_normal();
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 3) step();
        check("stream_accepts", 128'(dut_acc - base_acc), 128'd200);
        check("stream_results", 128'(n_res - base_res), 128'd200);
        check("stream_gap_free", 128'(last_res - first_res + 1), 128'd200);

        // Random mix of classes, handshakes and issue gating
        for (int i = 0; i < 600; i++) begin
            a_i      = rnd_any();
            b_i      = ($urandom_range(0, 7) == 0) ? {~a_i[15], a_i[14:0]} : rnd_any();
            in_valid = 1'($urandom);
            issue_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) reset = 1'b0;
            else                             reset = 1'b1;
            step();
        end
        reset    = 1'b1;
        in_valid = 1'b0;
        issue_en = 1'b1;
        repeat (LAT + 4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bf16_add_unpack.md
# bf16_add_unpack

Operand front-end for the bf16 adder pipeline. It accepts pairs of raw bf16 operands over a valid/ready handshake and buffers them in a 2-entry FIFO. It decodes each pair into the extended-mantissa, offset-exponent, sign and exception fields the adder core consumes, and issues at most one pair per cycle while `issue_en` is high. A LAT-deep valid delay line marks the cycle in which the adder's `result` belongs to an issued pair.

## Interface
- `G`, 6 — guard bits; operand mantissa width is G+16.
- `LAT`, 4 — adder latency in cycles, from operands presented to `result` valid.
- `clk` input 1 — clock.
- `reset` input 1 — synchronous, active-low.
- `a_i` input 16 — bf16 operand A.
- `b_i` input 16 — bf16 operand B.
- `in_valid` input 1 — pair valid.
- `in_ready` output 1 — FIFO can accept a pair.
- `issue_en` input 1 — downstream permits an issue this cycle.
- `in1`, `in2` output G+16 — decoded mantissas.
- `exp_1`, `exp_2` output 32 — offset exponents.
- `s_in1`, `s_in2` output 1 — signs.
- `exc_flag_1`, `exc_flag_2` output 1 — operand is inf or NaN.
- `err_code_1`, `err_code_2` output 1 — result must be NaN.
- `op_valid` output 1 — operand outputs carry an issued pair.
- `res_valid` output 1 — adder `result` is valid this cycle.
- `occupancy` output 2 — FIFO entries held (0..2).

## Operation
- **Accept.** A pair is accepted on an edge where `in_valid && in_ready`. `in_ready = (occupancy != 2)`, evaluated combinationally from registered state.
- **Issue.** When `issue_en` is high and the FIFO is non-empty, the head pair is decoded into the operand output registers and popped. `op_valid` is registered and set to 1 on that edge.
- **Idle output.** If no issue occurs, the operand registers load the idle value and `op_valid` is 0. Idle value: mantissa 0, exp 127, sign 0, exc 0, err 0.
- **Simultaneous events.**
  - Push and pop on the same edge leave occupancy unchanged.
  - When full, a pop on an edge frees `in_ready` only for the next cycle; there is no same-cycle pass-through.
  - When empty, a pair pushed on edge N issues no earlier than edge N+1.
- **Decode** (per operand; e = bits[14:7], m = bits[6:0], s = bit 15):
  - Normal (0<e<255): mantissa = {(G+1)'b0, 1'b1, m, 7'b0}; exp = e + 127; exc = 0; err = 0.
  - Zero or subnormal (e==0): flush to zero. Mantissa 0; exp 127; sign preserved; exc 0.
  - e==255: mantissa 0; exp 127 + 255 = 382; exc = 1; err = (m != 0).
  - Pair rule: if both operands are infinities with opposite signs, set both err_code to 1 (inf − inf gives NaN).
- **Widths.** Exponent arithmetic is zero-extended to 32 bits before adding 127. The mantissa has the hidden bit at bit 14 and the 7 fraction bits at [13:7]; bits [6:0] are 0.
- **Valid tracking.** An LAT-bit shift register is fed by `op_valid`; `res_valid` is its last stage.

## Timing
- **Reset** (`reset==0` at an edge), taking effect at that edge:
  - occupancy = 0; `in_ready` = 0 while reset is asserted; FIFO pointers = 0.
  - Operand outputs = idle value; `op_valid` = 0; delay line cleared, so `res_valid` = 0.
  - In-flight pairs are discarded.
- **Latency.** Accept edge N, with an empty FIFO and `issue_en` high → `op_valid` high after edge N+1 → `res_valid` high after edge N+1+LAT.
- **Throughput.** One pair per cycle sustained with `issue_en` held high.
- **Backpressure.** With `issue_en` low, the FIFO fills after 2 accepts and `in_ready` drops. Data is never overwritten or dropped.

## Structure
- **Shared package `bf16_pkg`:**
  - Constants: EXP_OFFSET=127, EXP_SPECIAL=8'hFF, idle operand value.
  - Struct for a decoded operand: mant, exp, s, exc, err.
- **Sub-module `bf16_unpack_op`:** combinational single-operand decoder, instantiated twice. The pair rule lives in the parent.

## Test plan
- 0x3F80 + 0x3F80, `issue_en`=1 → `in1`=`in2`=0x004000, `exp`=254, `op_valid` at N+1, `res_valid` at N+5 with adder `result` 0x4000.
- 0x7F80 + 0xFF80 → both `exc`=1, both `err`=1; adder `result` is NaN (0x7F81 or 0xFF81).
- 0x0001 (subnormal) + 0x8000 → both mantissas 0, both exp 127, `s_in2`=1, `exc`=0.
- `issue_en`=0 with 3 back-to-back pairs offered → 2 accepted, `in_ready`=0, occupancy=2. Raising `issue_en` issues them in order, then the third is accepted and issued.
- Assert reset mid-stream with occupancy 2 and delay line full → next cycle occupancy=0, `op_valid`=0, `res_valid`=0, operands at idle value.
- Continuous random normal pairs with `issue_en`=1 → one `res_valid` per accepted pair, in order, gap-free.
